// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard block: fwd_sel codes and the mul/div FSM states.
package fwd_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/fwd_slot_cmp.sv
// One EX source operand versus the MEM and WB destinations; combinational, MEM wins over WB.
module fwd_slot_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wb,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wb,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_wb && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wb && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding selects, load-use / mul-div stall generation and a mul/div busy tracker.
// Optional performance counters are compiled in with the FWD_STATS_EN macro.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MD_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_md,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_wb,
  input  logic                      ex_mem_read,
  input  logic                      ex_md_start,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_wb,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_wb,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      md_busy,
  output logic                      md_done,
  output logic [31:0]               stat_stall,
  output logic [31:0]               stat_fwd
);

  localparam int CW = $clog2(MD_LAT) + 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [REG_AW-1:0] md_rd;
  logic              md_wb;
  logic              lu_hit, md_hit;
  logic              load_use, md_hazard;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    fwd_slot_cmp #(.REG_AW(REG_AW)) u_cmp (
      .rs     (ex_rs[g*REG_AW +: REG_AW]),
      .mem_rd (mem_rd),
      .mem_wb (mem_wb),
      .wb_rd  (wb_rd),
      .wb_wb  (wb_wb),
      .sel    (fwd_sel[2*g +: 2])
    );
  end

  always_comb begin
    lu_hit = 1'b0;
    md_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i]) begin
        if (id_rs[i*REG_AW +: REG_AW] == ex_rd) lu_hit = 1'b1;
        if (id_rs[i*REG_AW +: REG_AW] == md_rd) md_hit = 1'b1;
      end
    end
  end

  // The completion cycle releases the consumer: the result is available on md_done.
  assign load_use  = ex_mem_read && ex_wb && (ex_rd != '0) && lu_hit;
  assign md_hazard = md_busy && !md_done && (id_md || (md_wb && (md_rd != '0) && md_hit));
  assign stall     = load_use || md_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      md_rd <= '0;
      md_wb <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == RUN) && (state_nxt == MD_BUSY)) begin
        cnt   <= CW'(MD_LAT - 1);
        md_rd <= ex_rd;
        md_wb <= ex_wb;
      end else if (state == MD_BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ex_md_start && !stall) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == CW'(1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    md_busy = (state == MD_BUSY);
    md_done = (state == MD_BUSY) && (cnt == CW'(1));
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
    end else begin
      if (stall) stat_stall <= stat_stall + 32'd1;
      if (|fwd_sel) stat_fwd <= stat_fwd + 32'd1;
    end
  end
`else
  assign stat_stall = '0;
  assign stat_fwd   = '0;
`endif

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source operands per instruction (1..4).
REQ-002 Parameter REG_AW, default 5: register-address width; register 0 is hard-wired zero.
REQ-003 Parameter MD_LAT, default 4: multiply/divide latency in cycles, at least 2.
REQ-004 Port clk  in  1  single clock; all state on the rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port id_rs  in  NUM_SRC*REG_AW  ID-stage source addresses; slot i occupies bits [i*REG_AW +: REG_AW].
REQ-007 Port id_rs_used  in  NUM_SRC  per-slot valid for id_rs.
REQ-008 Port id_md  in  1  ID instruction is a mul/div.
REQ-009 Port ex_rs  in  NUM_SRC*REG_AW  EX-stage source addresses, same packing as id_rs.
REQ-010 Port ex_rd, ex_wb, ex_mem_read  in  REG_AW,1,1  EX destination, write-enable, load flag.
REQ-011 Port ex_md_start  in  1  EX instruction starts a mul/div.
REQ-012 Port mem_rd, mem_wb  in  REG_AW,1  MEM destination and write-enable.
REQ-013 Port wb_rd, wb_wb  in  REG_AW,1  WB destination and write-enable.
REQ-014 Port fwd_sel  out  2*NUM_SRC  per-slot select: 00 regfile, 01 WB, 10 MEM; 11 is never driven.
REQ-015 Port stall  out  1  hold PC and IF/ID, and insert a bubble into EX.
REQ-016 Port md_busy, md_done  out  1,1  mul/div in flight; one-cycle completion pulse.
REQ-017 Port stat_stall, stat_fwd  out  32,32  performance counters (see Configuration).

Function
REQ-018 fwd_sel is combinational. For each slot, the select is 10 when mem_wb, mem_rd != 0 and mem_rd == the slot's ex_rs.
REQ-019 Otherwise the select is 01 under the same conditions on wb_wb/wb_rd; otherwise 00.
REQ-020 MEM has priority over WB when both match.
REQ-021 A load-use hazard exists when ex_mem_read, ex_wb, ex_rd != 0, and any used id_rs slot equals ex_rd.
REQ-022 The FSM has two states, RUN and MD_BUSY; the reset state is RUN.
REQ-023 RUN -> MD_BUSY when ex_md_start is 1 and stall is 0.
REQ-024 On that transition the block loads the counter with MD_LAT-1 and captures md_rd = ex_rd and md_wb = ex_wb.
REQ-025 In MD_BUSY the counter decrements each cycle.
REQ-026 When the counter equals 1, md_done pulses high for one cycle and the next state is RUN; total busy cycles = MD_LAT-1.
REQ-027 md_busy = (state == MD_BUSY).
REQ-028 An MD hazard exists in MD_BUSY when id_md = 1, or when md_wb, md_rd != 0 and any used id_rs slot equals md_rd.
REQ-029 stall = load-use hazard OR MD hazard; it is combinational from inputs and registered state.
REQ-030 In the cycle md_done is high, the MD hazard is evaluated as absent, so an ID consumer proceeds.
REQ-031 ex_md_start while in MD_BUSY is ignored; the upstream stall on id_md guarantees it does not occur.
REQ-032 Duplicate sources in one instruction receive identical selects.

Reset
REQ-033 On rst: state = RUN, counter = 0, md_rd = 0, md_wb = 0, md_done = 0, stat counters = 0.
REQ-034 The outputs are then md_busy = 0 and stall = 0, unless a load-use hazard is presented combinationally.
REQ-035 Reset asserted mid-operation abandons the mul/div with no md_done pulse.

Configuration
REQ-036 The macro FWD_STATS_EN compiles the performance counters in or out.
REQ-037 With FWD_STATS_EN defined, stat_stall increments every cycle stall = 1.
REQ-038 With FWD_STATS_EN defined, stat_fwd increments every cycle at least one fwd_sel slot is nonzero.
REQ-039 Both counters wrap at 2^32.
REQ-040 Without FWD_STATS_EN, both ports are tied to constant 0 and no counter flops exist.

Structure
REQ-041 The package fwd_pkg holds the fwd_sel encodings (FWD_RF, FWD_WB, FWD_MEM) and the FSM state enum.
REQ-042 The per-slot forward comparator is the sub-module fwd_slot_cmp, instantiated NUM_SRC times by generate.

Verification
REQ-043 Test: mem_wb=1, mem_rd=5, wb_wb=1, wb_rd=5, ex_rs slot0=5 -> fwd_sel slot0 = 10.
REQ-044 Test: wb_wb=1, wb_rd=0, ex_rs slot1=0 -> fwd_sel slot1 = 00.
REQ-045 Test: ex_mem_read=1, ex_wb=1, ex_rd=7, id_rs slot1=7, id_rs_used=2'b10 -> stall=1; with id_rs_used=2'b01 -> stall=0.
REQ-046 Test: MD_LAT=4, ex_md_start with ex_rd=9, then id_rs slot0=9 used -> stall for 2 cycles, md_done on the 3rd cycle with stall=0, md_busy falls after it.
REQ-047 Test: rst pulsed during MD_BUSY -> md_busy=0 immediately, no md_done pulse.
REQ-048 Test: with FWD_STATS_EN, 3 stall cycles and 2 forwarding cycles -> stat_stall=3, stat_fwd=2; without the macro both read 0.
